alu_share_arbiter: RTL

Sequences a single shared prv32 combinational ALU between two requesters: port 0 is the execute stage, port 1 is an auxiliary unit such as an address or compare engine. It accepts one operation at a time through a valid/ready handshake and drives the ALU operand and function inputs from registers. It captures the result and the flags {cf,zf,vf,sf} one cycle later and returns them to the requester that owns the operation, holding them until that requester accepts. Arbitration is round-robin by default.

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with a 3-state IDLE/EXEC/RESP sequencer.
// Define ALU_FIXED_PRIO_EN to replace round-robin with fixed priority for port 0.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int FN_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FN_W-1:0]  req0_fn,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FN_W-1:0]  req1_fn,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_r,
    output logic [3:0]       resp_flags,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FN_W-1:0]  alu_fn,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cf,
    input  logic             alu_zf,
    input  logic             alu_vf,
    input  logic             alu_sf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   owner;
    logic   sel;
    logic   accept;
    logic   resp_take;

`ifndef ALU_FIXED_PRIO_EN
    logic   rr_ptr;
`endif

    // Both valid: fixed build favours port 0, round-robin favours the port not served last.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~rr_ptr;
`endif
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;

    assign resp0_valid = (state == RESP) && !owner;
    assign resp1_valid = (state == RESP) && owner;
    assign resp_take   = (state == RESP) && (owner ? resp1_ready : resp0_ready);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (resp_take) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) owner <= sel;
        end
    end

`ifndef ALU_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (resp_take) begin
            rr_ptr <= owner;
        end
    end
`endif

    // Operand registers only load on acceptance, so later requester changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_fn <= '0;
        end else if (accept) begin
            alu_a  <= sel ? req1_a  : req0_a;
            alu_b  <= sel ? req1_b  : req0_b;
            alu_fn <= sel ? req1_fn : req0_fn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r     <= '0;
            resp_flags <= '0;
        end else if (state == EXEC) begin
            resp_r     <= alu_r;
            resp_flags <= {alu_cf, alu_zf, alu_vf, alu_sf};
        end
    end

endmodule
